scrambler_xor_stage_7: RTL and testbench
========================================

// Module: scrambler_xor_stage_7
// PURPOSE
//  Downstream consumer of primary_lfsr_7. XORs a valid/ready stream of DATA_WIDTH-bit words with keystream
//  taken from the LFSR state. Drives the LFSR enable, one pulse per accepted beat.
//  Snoops the same config bus (write/addr/lfsrdin) to track seeding and to stall while the LFSR is reloaded.
//  Emits scrambled words through a 2-entry output buffer with full backpressure.
// PARAMETERS
//  POLY_WIDTH   342    LFSR state width; must match primary_lfsr_7
//  DATA_WIDTH   16     word width; equals the LFSR NUM_OF_STEPS
//  SEED_BASE    12'h0ac first LFSR seed word address; 11 words SEED_BASE..SEED_BASE+10
//  CTRL_ADDR    12'h0b7 control register address
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           asynchronous active-low reset
//  write        in   1           config write strobe (shared with LFSR)
//  addr         in   12          config address
//  lfsrdin      in   32          config write data
//  lfsr_dout    in   POLY_WIDTH  LFSR state
//  lfsr_enable  out  1           advance LFSR DATA_WIDTH steps at next edge
//  in_valid     in   1           input word valid
//  in_ready     out  1           input word accepted when in_valid&in_ready
//  in_data      in   DATA_WIDTH  plaintext word
//  in_last      in   1           last word of frame
//  out_valid    out  1           output word valid
//  out_ready    in   1           sink accepts output
//  out_data     out  DATA_WIDTH  scrambled word
//  out_last     out  1           in_last carried with the word
//  seeded       out  1           all 11 seed words written since last clear
// BEHAVIOUR
//  Reset values: lfsr_enable=0, in_ready=0, out_valid=0, out_data=0, out_last=0, seeded=0.
//    State is IDLE, seed_mask=0, buffer count=0, bypass=0.
//  cfg_hit = write & addr in [SEED_BASE, SEED_BASE+10].
//    On each hit, set seed_mask[addr-SEED_BASE]. seeded = &seed_mask (11 bits).
//  CTRL write, lfsrdin bits:
//    [0] run: 1 -> RUN, 0 -> IDLE.
//    [1] bypass: registered; keystream forced to 0.
//    [2] clear_seed: seed_mask <= 0, applied before this cycle's hit, same cycle.
//  FSM states: IDLE, RUN, GUARD.
//    IDLE -> RUN on CTRL run=1 with seeded=1 or bypass=1; otherwise the block stays in IDLE.
//    RUN -> GUARD on cfg_hit.
//    GUARD -> RUN after one cycle with no cfg_hit. Consecutive hits hold the block in GUARD.
//    Any state -> IDLE on CTRL run=0. Buffered words still drain.
//  in_ready = (state==RUN) & ~cfg_hit & (count<2). Combinational in count and state only, never in in_valid.
//  lfsr_enable = in_valid & in_ready. It is never 1 in a cycle with cfg_hit, because the LFSR gives enable
//    priority over a load.
//  keystream = bypass ? 0 : lfsr_dout[POLY_WIDTH-1 -: DATA_WIDTH], sampled in the accept cycle.
//    The next beat sees the advanced state. Throughput is 1 word/cycle.
//  On accept, {in_data^keystream, in_last} is pushed into a 2-entry FIFO.
//    out_valid = count!=0. out_data and out_last come from the head entry.
//    Latency: accept at edge N -> out_valid at edge N+1.
//  Simultaneous push and pop: count is unchanged and the order is preserved.
//    count==2 with a pop frees in_ready only in the next cycle.
//  out_data and out_last are held stable while out_valid & ~out_ready.
//  Reset mid-frame: everything clears asynchronously. Partial frames are discarded and no beat is replayed.
// STRUCTURE
//  Shared package scr_pkg_7:
//    state enum {IDLE, RUN, GUARD}
//    SEED_WORDS=11, SEED_BASE, CTRL_ADDR
//    CTRL bit indices RUN_B=0, BYP_B=1, CLR_B=2
//  One sub-module, scr_obuf_2: 2-entry FIFO, width DATA_WIDTH+1, with count output.
//    The FSM, seed tracker and XOR stay in the top.
// TESTING
//  1 Reset, then CTRL run=1 with no seed:
//      -> state IDLE, in_ready=0, lfsr_enable never 1.
//  2 Write 0x0ac..0x0b5 = 0 and 0x0b6 = 0x3FFFFF, then CTRL=0x1, in_data=0x1234:
//      -> seeded=1; out_data=0xEDCB one cycle after accept; lfsr_enable pulses once.
//  3 Stream 8 words with out_ready=1:
//      -> 8 consecutive accepts, 8 enable pulses.
//      -> out_data matches a software model stepping 16 per word; out_last on word 8 only.
//  4 Hold out_ready=0 while streaming:
//      -> exactly 2 accepts, then in_ready=0 and out_data stable.
//      -> release: words 1,2 in order, ready returns the next cycle.
//  5 Write 0x0b0 during RUN with in_valid=1:
//      -> in_ready=0 and lfsr_enable=0 that cycle and the next GUARD cycle; resumes after.
//  6 CTRL=0x3 (bypass) then 0x5 (clear_seed):
//      -> out_data==in_data under bypass.
//      -> clear_seed gives seeded=0 and state IDLE when not bypassed; rst_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/scr_pkg_7.sv
// Shared types and constants for the keystream XOR stage that sits behind primary_lfsr_7.
package scr_pkg_7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int unsigned SEED_WORDS = 11;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned CFG_DW     = 32;

  localparam logic [ADDR_W-1:0] SEED_BASE = 12'h0ac;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = 12'h0b7;

  localparam int unsigned RUN_B = 0;
  localparam int unsigned BYP_B = 1;
  localparam int unsigned CLR_B = 2;

endpackage

// File: rtl/scr_obuf_2.sv
// Two-entry output FIFO; head entry is held until popped, order is preserved on push+pop.
module scr_obuf_2 #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  // slot0 is always the head; a pop shifts slot1 forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: slot0 <= push_data;
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/scrambler_xor_stage_7.sv
// XORs a valid/ready word stream with LFSR keystream, tracks seeding from the shared config bus
// and stalls while the LFSR is being reloaded.
module scrambler_xor_stage_7 #(
  parameter int unsigned POLY_WIDTH = 342,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [11:0] SEED_BASE  = scr_pkg_7::SEED_BASE,
  parameter logic [11:0] CTRL_ADDR  = scr_pkg_7::CTRL_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [11:0]           addr,
  input  logic [31:0]           lfsrdin,
  input  logic [POLY_WIDTH-1:0] lfsr_dout,
  output logic                  lfsr_enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  seeded
);

  import scr_pkg_7::state_t;
  import scr_pkg_7::IDLE;
  import scr_pkg_7::RUN;
  import scr_pkg_7::GUARD;
  import scr_pkg_7::SEED_WORDS;
  import scr_pkg_7::RUN_B;
  import scr_pkg_7::BYP_B;
  import scr_pkg_7::CLR_B;

  state_t                  state;
  state_t                  state_nxt;
  logic [SEED_WORDS-1:0]   seed_mask;
  logic [SEED_WORDS-1:0]   mask_nxt;
  logic                    bypass;
  logic                    cfg_hit;
  logic                    ctrl_wr;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   keystream;
  logic [DATA_WIDTH:0]     push_word;
  logic [DATA_WIDTH:0]     head;
  logic [1:0]              count;
  logic                    unused_ok;

  assign cfg_hit = write && (addr >= SEED_BASE) && (addr <= SEED_BASE + 12'(SEED_WORDS - 1));
  assign ctrl_wr = write && (addr == CTRL_ADDR);

  // clear_seed wipes the mask before this cycle's seed hit is recorded
  always_comb begin
    mask_nxt = seed_mask;
    if (ctrl_wr && lfsrdin[CLR_B]) mask_nxt = '0;
    for (int unsigned i = 0; i < SEED_WORDS; i++) begin
      if (cfg_hit && (addr == SEED_BASE + 12'(i))) mask_nxt[i] = 1'b1;
    end
  end

  // A CTRL write decides the state outright; otherwise seed reloads bounce RUN through GUARD
  always_comb begin
    state_nxt = state;
    if (ctrl_wr) begin
      state_nxt = (lfsrdin[RUN_B] && ((&mask_nxt) || lfsrdin[BYP_B])) ? RUN : IDLE;
    end else begin
      case (state)
        RUN:     if (cfg_hit)  state_nxt = GUARD;
        GUARD:   if (!cfg_hit) state_nxt = RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seed_mask <= '0;
      bypass    <= 1'b0;
    end else begin
      state     <= state_nxt;
      seed_mask <= mask_nxt;
      if (ctrl_wr) bypass <= lfsrdin[BYP_B];
    end
  end

  assign in_ready    = (state == RUN) && !cfg_hit && (count != 2'd2);
  assign accept      = in_valid && in_ready;
  assign lfsr_enable = accept;

  assign keystream = bypass ? '0 : lfsr_dout[POLY_WIDTH-1 -: DATA_WIDTH];
  assign push_word = {in_data ^ keystream, in_last};

  scr_obuf_2 #(
    .W (DATA_WIDTH + 1)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_word),
    .pop       (out_ready),
    .head      (head),
    .count     (count)
  );

  assign out_valid = (count != 2'd0);
  assign out_data  = head[DATA_WIDTH:1];
  assign out_last  = head[0];
  assign seeded    = &seed_mask;

  // only the keystream slice and the low control bits are consumed here
  assign unused_ok = ^{lfsr_dout[POLY_WIDTH-DATA_WIDTH-1:0], lfsrdin[31:3]};

endmodule

// File: tb/tb_scrambler_xor_stage_7.sv
// Bench for scrambler_xor_stage_7: a stand-in LFSR drives lfsr_dout, a queue-based model predicts outputs.
module tb_scrambler_xor_stage_7;

  localparam int unsigned PW = 342;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write = 1'b0;
  logic [11:0]   addr = '0;
  logic [31:0]   lfsrdin = '0;
  logic [PW-1:0] lfsr_dout;
  logic          lfsr_enable;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          seeded;

  int errs = 0;
  int checks = 0;
  int n_acc = 0;
  int n_en = 0;

  logic [PW-1:0] env_lfsr = '0;
  logic [PW-1:0] m_lfsr = '0;
  int            m_mode = 0;   // 0 idle, 1 run, 2 guard
  logic [10:0]   m_mask = '0;
  logic          m_byp = 1'b0;
  logic [DW:0]   m_q[$];

  scrambler_xor_stage_7 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write       (write),
    .addr        (addr),
    .lfsrdin     (lfsrdin),
    .lfsr_dout   (lfsr_dout),
    .lfsr_enable (lfsr_enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .seeded      (seeded)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] step16(input logic [PW-1:0] s);
    logic fb;
    for (int i = 0; i < 16; i++) begin
      fb = s[PW-1] ^ s[PW-3] ^ s[PW-7] ^ s[120];
      s  = {s[PW-2:0], fb};
    end
    return s;
  endfunction

  function automatic logic [PW-1:0] load_word(input logic [PW-1:0] s, input int k, input logic [31:0] d);
    for (int i = 0; i < 32; i++) begin
      if (32 * k + i < int'(PW)) s[32 * k + i] = d[i];
    end
    return s;
  endfunction

  function automatic logic is_seed(input logic [11:0] a);
    return (a >= 12'h0ac) && (a <= 12'h0b6);
  endfunction

  // stand-in for primary_lfsr_7: enable has priority over a seed load
  always @(posedge clk) begin
    if (lfsr_enable) env_lfsr <= step16(env_lfsr);
    else if (write && is_seed(addr)) env_lfsr <= load_word(env_lfsr, int'(addr - 12'h0ac), lfsrdin);
  end
  assign lfsr_dout = env_lfsr;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle, advances the model, returns at next posedge+1
  task automatic cycle();
    logic          hit, ctrl, rdy, acc, pop;
    logic [10:0]   mn;
    logic [DW-1:0] ks;
    #1;
    hit  = write && is_seed(addr);
    ctrl = write && (addr == 12'h0b7);
    rdy  = (m_mode == 1) && !hit && (m_q.size() < 2);
    chk1("in_ready", in_ready, rdy);
    chk1("lfsr_enable", lfsr_enable, in_valid && rdy);
    chk1("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk16("out_data", out_data, m_q[0][DW:1]);
      chk1("out_last", out_last, m_q[0][0]);
    end
    chk1("seeded", seeded, &m_mask);
    acc = in_valid && rdy;
    if (lfsr_enable) n_en++;
    if (acc) n_acc++;
    pop = out_ready && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    ks = m_byp ? '0 : m_lfsr[PW-1 -: DW];
    if (acc) begin
      m_q.push_back({in_data ^ ks, in_last});
      m_lfsr = step16(m_lfsr);
    end else if (hit) begin
      m_lfsr = load_word(m_lfsr, int'(addr - 12'h0ac), lfsrdin);
    end
    mn = m_mask;
    if (ctrl && lfsrdin[2]) mn = '0;
    if (hit) mn[int'(addr - 12'h0ac)] = 1'b1;
    if (ctrl) m_mode = (lfsrdin[0] && ((&mn) || lfsrdin[1])) ? 1 : 0;
    else if (hit && m_mode != 0) m_mode = 2;
    else if (m_mode == 2) m_mode = 1;
    if (ctrl) m_byp = lfsrdin[1];
    m_mask = mn;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    write = 1'b1; addr = a; lfsrdin = d;
    cycle();
    write = 1'b0; addr = '0; lfsrdin = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, e0;
    logic [DW-1:0] d;

    // reset values
    #3;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_enable", lfsr_enable, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_data", out_data, 16'h0000);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_seeded", seeded, 1'b0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: run without seed stays idle
    wr(12'h0b7, 32'h1);
    in_valid = 1'b1; in_data = 16'h5555;
    repeat (3) cycle();
    in_valid = 1'b0;
    chkn("t1_enables", n_en, 0);

    // 2: seed, run, single word
    for (int k = 0; k < 10; k++) wr(12'h0ac + 12'(k), 32'h0);
    wr(12'h0b6, 32'h003F_FFFF);
    chk1("t2_seeded", seeded, 1'b1);
    wr(12'h0b7, 32'h1);
    e0 = n_en;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk1("t2_valid", out_valid, 1'b1);
    chk16("t2_out", out_data, 16'hEDCB);
    cycle();
    chkn("t2_pulses", n_en - e0, 1);

    // 3: stream 8 words back to back
    a0 = n_acc; e0 = n_en;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_last = (i == 7);
      cycle();
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) cycle();
    chkn("t3_accepts", n_acc - a0, 8);
    chkn("t3_pulses", n_en - e0, 8);

    // 4: backpressure fills the buffer, then release
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'($urandom);
      cycle();
    end
    chkn("t4_accepts", n_acc - a0, 2);
    out_ready = 1'b1;
    repeat (4) cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // 5: seed reload during a stream stalls for hit + guard cycle
    in_valid = 1'b1; in_data = 16'($urandom);
    cycle();
    write = 1'b1; addr = 12'h0b0; lfsrdin = $urandom;
    cycle();
    write = 1'b0; addr = '0; lfsrdin = '0;
    chk1("t5_guard_ready", in_ready, 1'b0);
    repeat (3) begin
      in_data = 16'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // random traffic with sporadic seed reloads
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_data = 16'($urandom); in_last = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        write = 1'b1; addr = 12'h0ac + 12'($urandom_range(0, 10)); lfsrdin = $urandom;
      end else begin
        write = 1'b0; addr = '0; lfsrdin = '0;
      end
      cycle();
    end
    write = 1'b0; addr = '0; lfsrdin = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // 6: bypass passes data through unchanged
    wr(12'h0b7, 32'h3);
    d = 16'($urandom);
    in_valid = 1'b1; in_data = d; in_last = 1'b1;
    cycle();
    in_valid = 1'b0; in_last = 1'b0;
    chk16("t6_bypass", out_data, d);
    cycle();
    // clear_seed without bypass drops back to idle
    wr(12'h0b7, 32'h5);
    chk1("t6_cleared", seeded, 1'b0);
    in_valid = 1'b1;
    cycle();
    chk1("t6_idle_ready", in_ready, 1'b0);
    // bypass run with a full buffer, then reset mid-frame
    wr(12'h0b7, 32'h3);
    out_ready = 1'b0;
    repeat (3) begin
      in_data = 16'($urandom);
      cycle();
    end
    chk1("t6_full_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_ready", in_ready, 1'b0);
    chk1("t6_rst_enable", lfsr_enable, 1'b0);
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk16("t6_rst_data", out_data, 16'h0000);
    chk1("t6_rst_last", out_last, 1'b0);
    chk1("t6_rst_seeded", seeded, 1'b0);
    m_mode = 0; m_mask = '0; m_byp = 1'b0; m_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
